// File: rtl/mem_master_pkg.sv
// Shared widths and FSM encoding for the mem_master CPU-to-memory bridge.
package mem_master_pkg;

    localparam int unsigned ADDR_W_DEF = 11;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } state_e;

endpackage

// File: rtl/mem_rdcache.sv
// One-entry last-read register (valid, tag, data) used by mem_master when
// MEM_MASTER_RDCACHE_EN is defined; filled on memory reads, written through on tag hits.
module mem_rdcache
    import mem_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_addr,
    input  logic              fill_en,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              hit_c,
    output logic [DATA_W-1:0] data
);

    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] tag_q,   tag_d;
    logic [DATA_W-1:0] data_q,  data_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_addr;
            data_d  = fill_data;
        end else if (wr_en && valid_q && (wr_addr == tag_q)) begin
            data_d  = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit_c = valid_q && (lookup_addr == tag_q);
    assign data  = data_q;

endmodule

// File: rtl/mem_master.sv
// CPU request to single-port memory bridge: one access at a time, registered strobes.
// Optional one-entry read cache enabled by defining MEM_MASTER_RDCACHE_EN.
module mem_master
    import mem_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_data_out
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic              mem_rd_q, mem_rd_d;
    logic              mem_wr_q, mem_wr_d;

    logic              hit_c;
    logic [DATA_W-1:0] cache_data;

`ifdef MEM_MASTER_RDCACHE_EN
    mem_rdcache #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_rdcache (
        .clk         (clk),
        .rst         (rst),
        .lookup_addr (addr),
        .fill_en     (state_q == RD_WAIT),
        .fill_addr   (mem_address_q),
        .fill_data   (mem_data_out),
        .wr_en       (state_q == WR_ISSUE),
        .wr_addr     (mem_address_q),
        .wr_data     (mem_data_in_q),
        .hit_c       (hit_c),
        .data        (cache_data)
    );
`else
    assign hit_c      = 1'b0;
    assign cache_data = '0;
`endif

    // Next state and registered outputs; a cache hit sits in RD_ISSUE with mem_rd low.
    always_comb begin
        state_d       = state_q;
        done_d        = 1'b0;
        mem_rd_d      = 1'b0;
        mem_wr_d      = 1'b0;
        rdata_d       = rdata_q;
        mem_address_d = mem_address_q;
        mem_data_in_d = mem_data_in_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    mem_address_d = addr;
                    mem_data_in_d = wdata;
                    if (we) begin
                        state_d  = WR_ISSUE;
                        mem_wr_d = 1'b1;
                    end else begin
                        state_d  = RD_ISSUE;
                        mem_rd_d = !hit_c;
                    end
                end
            end
            RD_ISSUE: begin
                if (mem_rd_q) begin
                    state_d = RD_WAIT;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    rdata_d = cache_data;
                end
            end
            RD_WAIT: begin
                state_d = IDLE;
                done_d  = 1'b1;
                rdata_d = mem_data_out;
            end
            WR_ISSUE: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            ready_q       <= 1'b1;
            done_q        <= 1'b0;
            rdata_q       <= '0;
            mem_address_q <= '0;
            mem_data_in_q <= '0;
            mem_rd_q      <= 1'b0;
            mem_wr_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ready_q       <= ready_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
            mem_address_q <= mem_address_d;
            mem_data_in_q <= mem_data_in_d;
            mem_rd_q      <= mem_rd_d;
            mem_wr_q      <= mem_wr_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign rdata       = rdata_q;
    assign mem_address = mem_address_q;
    assign mem_data_in = mem_data_in_q;
    assign mem_rd      = mem_rd_q;
    assign mem_wr      = mem_wr_q;

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter ADDR_W, default 11, memory address width (2048 words).
REQ-002 Parameter DATA_W, default 16, memory data word width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req  input  1  CPU access request, sampled only when ready=1.
REQ-007 we  input  1  1=write, 0=read; qualified by req.
REQ-008 addr  input  ADDR_W  CPU word address.
REQ-009 wdata  input  DATA_W  CPU write data.
REQ-010 ready  output  1  high in IDLE; request accepted on edge where req&ready.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 rdata  output  DATA_W  read result, valid when done after a read; holds until next read completes.
REQ-013 mem_address  output  ADDR_W  address to memory (registered).
REQ-014 mem_data_in  output  DATA_W  write data to memory (registered).
REQ-015 mem_rd, mem_wr  output  1 each  memory read/write strobes (registered).
REQ-016 mem_data_out  input  DATA_W  memory read data; memory updates it on the rising edge where it samples mem_rd=1.

Function
REQ-017 The block SHALL implement FSM states IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE; ready=1 only in IDLE.
REQ-018 On accept, addr/wdata SHALL be captured into mem_address/mem_data_in; CPU need not hold them afterwards.
REQ-019 Read accept (edge k): RD_ISSUE with mem_rd=1 for exactly one cycle; edge k+1 -> RD_WAIT, mem_rd=0; edge k+2 rdata<=mem_data_out, done=1, -> IDLE (latency 2 edges).
REQ-020 Write accept (edge k): WR_ISSUE with mem_wr=1 for exactly one cycle; edge k+1 done=1, mem_wr=0, -> IDLE.
REQ-021 mem_rd and mem_wr SHALL never be high together; both low in IDLE and RD_WAIT.
REQ-022 req while not ready SHALL be ignored (no queueing); req in the done cycle SHALL be accepted (back-to-back, ready=1).
REQ-023 done SHALL be high exactly one cycle per accepted request; rdata unchanged on write completion.

Reset
REQ-024 rst=1 SHALL immediately force IDLE, ready=1, done=0, mem_rd=0, mem_wr=0, rdata=0, mem_address=0, mem_data_in=0.
REQ-025 Reset mid-operation SHALL abandon the access without a done pulse; a write whose mem_wr edge was not reached is lost.

Configuration
REQ-026 Macro MEM_MASTER_RDCACHE_EN defined: one-entry last-read register (valid, tag, data); read hit (valid & addr==tag) SHALL skip memory, no mem_rd, done on edge k+1 with cached data.
REQ-027 With MEM_MASTER_RDCACHE_EN: every memory read completion loads tag/data, valid=1; write to tag address updates cached data with wdata (write-through, memory still written); reset clears valid.
REQ-028 Macro undefined: no cache logic; every read uses the 2-edge memory path.

Structure
REQ-029 Package mem_master_pkg SHALL hold ADDR_W/DATA_W defaults and the FSM state typedef/encodings.
REQ-030 Sub-module mem_rdcache SHALL hold the last-read register, instantiated only under MEM_MASTER_RDCACHE_EN; FSM stays in mem_master.

Verification (bench model: memory per REQ-016, preloaded mem[10]=0009, mem[11]=FFFC, mem[12]=0000)
REQ-031 Read addr=10 -> mem_rd one cycle, done 2 edges after accept, rdata=0009.
REQ-032 Write addr=12 wdata=1234, then read addr=12 in done cycle -> write done 1 edge after accept, read rdata=1234, mem_rd/mem_wr never overlap.
REQ-033 req held high during RD_ISSUE/RD_WAIT with addr=11 -> ignored, single done, only one mem_rd pulse.
REQ-034 rst asserted during RD_WAIT -> outputs to reset values asynchronously, no done, ready=1 next cycle.
REQ-035 Cache enabled: read 11 twice -> second read no mem_rd, done 1 edge after accept, rdata=FFFC; write 11=AAAA then read 11 -> AAAA from cache.
